// File: rtl/rf_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter_if
// Description : Requester-side bundle for the register-file writeback arbiter.
//               One valid/ready handshake per requester, with the destination
//               register and write data packed per requester index.
// Signals     : req_valid_i  [NUM_REQ]     requester i wants to write
//               req_ready_o  [NUM_REQ]     arbiter accepts requester i
//               req_addr_i   [NUM_REQ*5]   requester i at [5i+4:5i]
//               req_data_i   [NUM_REQ*32]  requester i at [32i+31:32i]
//               Directions in the names are as seen by the arbiter.
// Modports    : master (requesters), slave (arbiter)
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_wb_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [NUM_REQ*5-1:0]  req_addr_i;
    logic [NUM_REQ*32-1:0] req_data_i;

    modport master (
        output req_valid_i,
        output req_addr_i,
        output req_data_i,
        input  req_ready_o
    );

    modport slave (
        input  req_valid_i,
        input  req_addr_i,
        input  req_data_i,
        output req_ready_o
    );
endinterface
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Round-robin arbiter sharing the single register-file write
//               port among NUM_REQ writeback requesters. After reset it first
//               writes $gp (r28) and $sp (r29), then serves requesters. The
//               write port outputs are registered and drive the register file
//               directly. Writes to r0 complete the handshake but are never
//               presented to the register file.
// Ports       : clk, rst          clock, asynchronous active-high reset
//               stall_i           blocks every grant while in RUN
//               bus (slave)       per-requester valid/ready/addr/data
//               wr_en_o           register-file write enable
//               wr_reg_o [5]      register-file write address
//               wr_data_o [32]    register-file write data
//               grant_id_o        index of the last accepted requester
//               init_done_o       high once the init writes are issued
//               stall_cnt_o       (RF_WB_ARB_STATS_EN only) per-requester
//                                 16-bit saturating wait counters
// Options     : define RF_WB_ARB_STATS_EN to add stall_cnt_o and its counters
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
    parameter int          NUM_REQ = 3,
    parameter logic [31:0] GP_INIT = 32'h1000_8000,
    parameter logic [31:0] SP_INIT = 32'h7FFF_EFFC
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall_i,
    rf_wb_arbiter_if.slave             bus,
    output logic                       wr_en_o,
    output logic [4:0]                 wr_reg_o,
    output logic [31:0]                wr_data_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       init_done_o
`ifdef RF_WB_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]      stall_cnt_o
`endif
);

    localparam int                c_ID_W    = $clog2(NUM_REQ);
    localparam logic [c_ID_W:0]   c_NUM     = (c_ID_W+1)'(NUM_REQ);
    localparam logic [c_ID_W-1:0] c_PTR_RST = c_ID_W'(NUM_REQ - 1);
    localparam logic [4:0]        c_GP_REG  = 5'd28;
    localparam logic [4:0]        c_SP_REG  = 5'd29;

    typedef enum logic [1:0] {
        S_INIT_GP = 2'd0,
        S_INIT_SP = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_ID_W-1:0]   r_ptr;

    logic                w_found;
    logic [c_ID_W-1:0]   w_sel;
    logic [c_ID_W:0]     w_sum;
    logic [NUM_REQ-1:0]  w_ready;
    logic [4:0]          w_addr;
    logic [31:0]         w_data;

    // Round-robin search starting one past the last winner. The sum is one
    // bit wider than the pointer so ptr+k (at most 2*NUM_REQ-1) never wraps
    // before the explicit modulo subtraction.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        if (r_state == S_RUN && !stall_i) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                w_sum = {1'b0, r_ptr} + (c_ID_W+1)'(k);
                if (w_sum >= c_NUM) begin
                    w_sum = w_sum - c_NUM;
                end
                if (!w_found && bus.req_valid_i[w_sum[c_ID_W-1:0]]) begin
                    w_found = 1'b1;
                    w_sel   = w_sum[c_ID_W-1:0];
                end
            end
        end
    end

    assign w_ready         = w_found ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel) : '0;
    assign bus.req_ready_o = w_ready;
    assign w_addr          = bus.req_addr_i[w_sel*5 +: 5];
    assign w_data          = bus.req_data_i[w_sel*32 +: 32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_INIT_GP;
            r_ptr       <= c_PTR_RST;
            wr_en_o     <= 1'b0;
            wr_reg_o    <= '0;
            wr_data_o   <= '0;
            grant_id_o  <= '0;
            init_done_o <= 1'b0;
        end else begin
            case (r_state)
                S_INIT_GP: begin
                    wr_en_o   <= 1'b1;
                    wr_reg_o  <= c_GP_REG;
                    wr_data_o <= GP_INIT;
                    r_state   <= S_INIT_SP;
                end
                S_INIT_SP: begin
                    wr_en_o     <= 1'b1;
                    wr_reg_o    <= c_SP_REG;
                    wr_data_o   <= SP_INIT;
                    init_done_o <= 1'b1;
                    r_state     <= S_RUN;
                end
                S_RUN: begin
                    if (w_found) begin
                        // r0 is hardwired zero: consume the request but
                        // keep the register file write disabled.
                        wr_en_o    <= (w_addr != 5'd0);
                        wr_reg_o   <= w_addr;
                        wr_data_o  <= w_data;
                        grant_id_o <= w_sel;
                        r_ptr      <= w_sel;
                    end else begin
                        wr_en_o <= 1'b0;
                    end
                end
                default: begin
                    wr_en_o <= 1'b0;
                    r_state <= S_INIT_GP;
                end
            endcase
        end
    end

`ifdef RF_WB_ARB_STATS_EN
    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_stall_cnt
            logic [15:0] r_cnt;

            // Counts every cycle a requester waits, INIT cycles included.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (bus.req_valid_i[g] && !w_ready[g] && r_cnt != 16'hFFFF) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end

            assign stall_cnt_o[g*16 +: 16] = r_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wb_arbiter
// Description : Self-checking bench for rf_wb_arbiter. A driver applies
//               directed and randomized requester traffic, a reference model
//               predicts ready and write-port outputs per cycle and queues
//               them, and independent monitors compare the DUT against the
//               queued expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

    localparam int          N  = 3;
    localparam int          W  = $clog2(N);
    localparam logic [31:0] GP = 32'h1000_8000;
    localparam logic [31:0] SP = 32'h7FFF_EFFC;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic stall = 1'b0;

    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.NUM_REQ(N)) bus ();

    logic          wr_en;
    logic [4:0]    wr_reg;
    logic [31:0]   wr_data;
    logic [W-1:0]  grant_id;
    logic          init_done;
`ifdef RF_WB_ARB_STATS_EN
    logic [N*16-1:0] stall_cnt;
`endif

    rf_wb_arbiter #(
        .NUM_REQ (N),
        .GP_INIT (GP),
        .SP_INIT (SP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall),
        .bus         (bus),
        .wr_en_o     (wr_en),
        .wr_reg_o    (wr_reg),
        .wr_data_o   (wr_data),
        .grant_id_o  (grant_id),
        .init_done_o (init_done)
`ifdef RF_WB_ARB_STATS_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    typedef struct packed {
        logic         en;
        logic [4:0]   rg;
        logic [31:0]  d;
        logic [W-1:0] gid;
        logic         done;
    } out_t;

    out_t         q_out[$];
    logic [N-1:0] q_rdy[$];

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state: requester-side pending requests, cycles since
    // reset release, last winner, expected output registers, wait counters.
    bit          pend   [N];
    logic [4:0]  p_addr [N];
    logic [31:0] p_data [N];
    int          m_cnt  [N];
    int          m_edges;
    int          m_last;
    out_t        m_out;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus.req_valid_i[i]          = pend[i];
            bus.req_addr_i[i*5 +: 5]    = p_addr[i];
            bus.req_data_i[i*32 +: 32]  = p_data[i];
        end
    endtask

    // One clock cycle: drive, predict, queue expectations, advance.
    task automatic step(input bit st);
        int pick;
        logic [N-1:0] exp_rdy;
        stall = st;
        apply();
        pick = -1;
        if (m_edges >= 2 && !st) begin
            for (int j = 1; j <= N; j++) begin
                int idx;
                idx = (m_last + j) % N;
                if (pick < 0 && pend[idx]) pick = idx;
            end
        end
        exp_rdy = '0;
        if (pick >= 0) exp_rdy[pick] = 1'b1;
        q_rdy.push_back(exp_rdy);
        for (int i = 0; i < N; i++) begin
            if (pend[i] && i != pick && m_cnt[i] < 65535) m_cnt[i]++;
        end
        if (m_edges == 0) begin
            m_out.en = 1'b1; m_out.rg = 5'd28; m_out.d = GP;
        end else if (m_edges == 1) begin
            m_out.en = 1'b1; m_out.rg = 5'd29; m_out.d = SP; m_out.done = 1'b1;
        end else if (pick >= 0) begin
            m_out.en  = (p_addr[pick] != 5'd0);
            m_out.rg  = p_addr[pick];
            m_out.d   = p_data[pick];
            m_out.gid = W'(pick);
            m_last    = pick;
            pend[pick] = 1'b0;
        end else begin
            m_out.en = 1'b0;
        end
        m_edges++;
        q_out.push_back(m_out);
        @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        stall = 1'b0;
        apply();
        #1;
        chk("rst_wr_en",     32'(wr_en),     32'd0);
        chk("rst_wr_reg",    32'(wr_reg),    32'd0);
        chk("rst_wr_data",   wr_data,        32'd0);
        chk("rst_grant_id",  32'(grant_id),  32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_ready",     32'(bus.req_ready_o), 32'd0);
        m_edges = 0;
        m_last  = N - 1;
        m_out   = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
`ifdef RF_WB_ARB_STATS_EN
        chk("rst_stall_cnt", 32'(stall_cnt[15:0]), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic rand_req(input int pct);
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(99) < pct) begin
                pend[i]   = 1'b1;
                p_addr[i] = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
                p_data[i] = $urandom;
            end
        end
    endtask

    // Output monitor: registered write port, just after each rising edge.
    out_t mon_e;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q_out.size() > 0) begin
                mon_e = q_out.pop_front();
                chk("wr_en",     32'(wr_en),     32'(mon_e.en));
                chk("wr_reg",    32'(wr_reg),    32'(mon_e.rg));
                chk("wr_data",   wr_data,        mon_e.d);
                chk("grant_id",  32'(grant_id),  32'(mon_e.gid));
                chk("init_done", 32'(init_done), 32'(mon_e.done));
            end
        end
    end

    // Ready monitor: combinational accept, mid-cycle.
    logic [N-1:0] mon_r;
    initial begin
        forever begin
            @(negedge clk);
            if (q_rdy.size() > 0) begin
                mon_r = q_rdy.pop_front();
                chk("req_ready", 32'(bus.req_ready_o), 32'(mon_r));
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; p_addr[i] = '0; p_data[i] = '0; m_cnt[i] = 0;
        end
        m_edges = 0; m_last = N - 1; m_out = '0;
        apply();
        #3;
        do_reset();

        // Init sequence with no requests.
        repeat (3) step(1'b0);

        // All requesters continuously valid: strict rotation 0,1,2,0,...
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) begin
                pend[i] = 1'b1; p_addr[i] = 5'(8 + i); p_data[i] = 32'hA + 32'(i);
            end
            step(1'b0);
        end
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        step(1'b0);

        // r0 write from requester 1 is consumed silently.
        pend[1] = 1'b1; p_addr[1] = 5'd0; p_data[1] = 32'hDEAD;
        step(1'b0);
        step(1'b0);

        // Stall blocks requester 2 for three cycles, then it is accepted.
        pend[2] = 1'b1; p_addr[2] = 5'd5; p_data[2] = 32'h1234_5678;
        repeat (3) step(1'b1);
`ifdef RF_WB_ARB_STATS_EN
        chk("stall_cnt2", 32'(stall_cnt[47:32]), 32'(m_cnt[2]));
`endif
        step(1'b0);
        step(1'b0);

        // Request already present during reset and INIT is held off.
        pend[0] = 1'b1; p_addr[0] = 5'd3; p_data[0] = 32'hCAFE_0000;
        do_reset();
        repeat (4) step(1'b0);

        // Randomized traffic with occasional stall.
        repeat (300) begin
            rand_req(60);
            step($urandom_range(9) < 2);
        end

        // Reset pulse while requesters 0 and 1 are pending.
        pend[0] = 1'b1; p_addr[0] = 5'd17; p_data[0] = $urandom;
        pend[1] = 1'b1; p_addr[1] = 5'd18; p_data[1] = $urandom;
        pend[2] = 1'b0;
        do_reset();
        repeat (5) step(1'b0);

        repeat (200) begin
            rand_req(50);
            step($urandom_range(9) < 3);
        end

`ifdef RF_WB_ARB_STATS_EN
        for (int i = 0; i < N; i++) begin
            chk("stall_cnt_final", 32'(stall_cnt[i*16 +: 16]), 32'(m_cnt[i]));
        end
`endif

        @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
